// File: rtl/mips_exc_pkg.sv
// Shared MIPS exception definitions: code width, ExcCode values, PC step and
// the commit-stage report-latch state type.
package mips_exc_pkg;

  localparam int EXC_W = 5;

  localparam logic [EXC_W-1:0] EXC_NONE    = 5'd0;
  localparam logic [EXC_W-1:0] EXC_INT     = 5'd0;
  localparam logic [EXC_W-1:0] EXC_ADEL    = 5'd4;
  localparam logic [EXC_W-1:0] EXC_ADES    = 5'd5;
  localparam logic [EXC_W-1:0] EXC_SYSCALL = 5'd8;
  localparam logic [EXC_W-1:0] EXC_RI      = 5'd10;
  localparam logic [EXC_W-1:0] EXC_OV      = 5'd12;

  localparam int PC_STEP = 4;

  typedef enum logic {
    REP_IDLE = 1'b0,
    REP_PEND = 1'b1
  } RepState_e;

endpackage

// File: rtl/exc_prio_sel.sv
// Combinational exception merge: upstream code first, then the lowest-index
// non-zero current-stage source. Also used standalone in non-commit stages.
module exc_prio_sel #(
  parameter int EXC_W = mips_exc_pkg::EXC_W,
  parameter int N_SRC = 4
) (
  input  logic                   inValid,
  input  logic [EXC_W-1:0]       inExc,
  input  logic [N_SRC*EXC_W-1:0] curExc,
  output logic [EXC_W-1:0]       merged
);

  logic [EXC_W-1:0] src [N_SRC];
  logic [EXC_W-1:0] firstHit;

  for (genvar gi = 0; gi < N_SRC; gi++) begin : gSrc
    assign src[gi] = curExc[gi*EXC_W +: EXC_W];
  end

  // Scan from the top down so the lowest index is the last writer and wins.
  always_comb begin
    firstHit = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (src[i] != '0) firstHit = src[i];
    end
  end

  assign merged = !inValid       ? '0    :
                  (inExc != '0)  ? inExc :
                                   firstHit;

endmodule

// File: rtl/exc_stage_reg.sv
// Exception-carrying pipeline stage register with the commit-stage precise
// exception report latch, pipeline kill and reported-exception counter.
module exc_stage_reg #(
  parameter int EXC_W = mips_exc_pkg::EXC_W,
  parameter int N_SRC = 4,
  parameter int PC_W  = 32,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [EXC_W-1:0]       in_exc,
  input  logic [PC_W-1:0]        in_pc,
  input  logic                   in_bd,
  input  logic [N_SRC*EXC_W-1:0] cur_exc,
  output logic                   out_valid,
  output logic [EXC_W-1:0]       out_exc,
  output logic [PC_W-1:0]        out_pc,
  output logic                   out_bd,
  output logic                   rep_valid,
  output logic [EXC_W-1:0]       rep_exc,
  output logic [PC_W-1:0]        rep_epc,
  output logic                   rep_bd,
  input  logic                   rep_ack,
  output logic                   kill,
  output logic [CNT_W-1:0]       exc_cnt
);
  import mips_exc_pkg::*;

  logic [EXC_W-1:0] merged;
  logic             trig;
  logic [PC_W-1:0]  epc;
  logic             loadRep;
  RepState_e        stateReg;

  exc_prio_sel #(
    .EXC_W(EXC_W),
    .N_SRC(N_SRC)
  ) uPrioSel (
    .inValid(in_valid),
    .inExc  (in_exc),
    .curExc (cur_exc),
    .merged (merged)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_exc   <= '0;
      out_pc    <= '0;
      out_bd    <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_exc   <= '0;
      out_pc    <= '0;
      out_bd    <= 1'b0;
    end else if (!stall) begin
      out_valid <= in_valid;
      out_exc   <= merged;
      out_pc    <= in_pc;
      out_bd    <= in_bd;
    end
  end

  assign trig = out_valid && (out_exc != '0);
  // A delay-slot fault must restart at the branch, one instruction earlier.
  assign epc  = out_bd ? (out_pc - PC_W'(PC_STEP)) : out_pc;

  // A new report is accepted when idle, or when CP0 frees the slot this cycle.
  assign loadRep = trig && ((stateReg == REP_IDLE) || rep_ack);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stateReg <= REP_IDLE;
      rep_exc  <= '0;
      rep_epc  <= '0;
      rep_bd   <= 1'b0;
      exc_cnt  <= '0;
    end else begin
      if (loadRep) begin
        rep_exc <= out_exc;
        rep_epc <= epc;
        rep_bd  <= out_bd;
        exc_cnt <= exc_cnt + CNT_W'(1);
      end
      case (stateReg)
        REP_IDLE: if (trig) stateReg <= REP_PEND;
        REP_PEND: if (rep_ack && !trig) stateReg <= REP_IDLE;
        default:  stateReg <= REP_IDLE;
      endcase
    end
  end

  assign rep_valid = (stateReg == REP_PEND);
  assign kill      = trig | rep_valid;

endmodule

// File: tb/tb_exc_stage_reg.sv
// Scoreboard bench for exc_stage_reg: directed scenarios plus random traffic,
// checked every cycle against a behavioural model of the stage and report latch.
module tb_exc_stage_reg;

  localparam int EW = 5;
  localparam int NS = 4;
  localparam int PW = 32;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          stall, flush, in_valid, in_bd, rep_ack;
  logic [EW-1:0] in_exc;
  logic [PW-1:0] in_pc;
  logic [NS*EW-1:0] cur_exc;
  logic          out_valid, out_bd, rep_valid, rep_bd, kill;
  logic [EW-1:0] out_exc, rep_exc;
  logic [PW-1:0] out_pc, rep_epc;
  logic [CW-1:0] exc_cnt;

  exc_stage_reg #(.EXC_W(EW), .N_SRC(NS), .PC_W(PW), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_exc(in_exc), .in_pc(in_pc), .in_bd(in_bd),
    .cur_exc(cur_exc), .out_valid(out_valid), .out_exc(out_exc),
    .out_pc(out_pc), .out_bd(out_bd), .rep_valid(rep_valid),
    .rep_exc(rep_exc), .rep_epc(rep_epc), .rep_bd(rep_bd),
    .rep_ack(rep_ack), .kill(kill), .exc_cnt(exc_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic [EW-1:0] exc;
    logic [PW-1:0] pc;
    logic          bd;
    logic          rv;
    logic [EW-1:0] rexc;
    logic [PW-1:0] repc;
    logic          rbd;
    logic          kl;
    int            cnt;
  } Exp_t;

  Exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   txn    = 0;

  // Behavioural reference state
  logic          mValid, mBd, mPend, mRepBd;
  logic [EW-1:0] mExc, mRepExc;
  logic [PW-1:0] mPc, mRepEpc;
  int            mCnt;

  logic [EW-1:0] codeTab [6] = '{5'd0, 5'd4, 5'd5, 5'd8, 5'd10, 5'd12};

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [EW-1:0] refMerge(logic v, logic [EW-1:0] up, logic [NS*EW-1:0] cur);
    if (!v) return '0;
    if (up != 0) return up;
    for (int i = 0; i < NS; i++)
      if (cur[i*EW +: EW] != 0) return cur[i*EW +: EW];
    return '0;
  endfunction

  task automatic modelReset();
    mValid = 0; mExc = 0; mPc = 0; mBd = 0;
    mPend = 0; mRepExc = 0; mRepEpc = 0; mRepBd = 0; mCnt = 0;
  endtask

  // One clock edge of the reference, using the pre-edge model state and inputs.
  task automatic modelEdge();
    Exp_t e;
    logic trigM;
    logic [PW-1:0] epcM;
    trigM = mValid && (mExc != 0);
    epcM  = mBd ? mPc - 32'd4 : mPc;
    if (!mPend) begin
      if (trigM) begin
        mPend = 1; mRepExc = mExc; mRepEpc = epcM; mRepBd = mBd; mCnt = (mCnt + 1) % (1 << CW);
      end
    end else if (rep_ack) begin
      if (trigM) begin
        mRepExc = mExc; mRepEpc = epcM; mRepBd = mBd; mCnt = (mCnt + 1) % (1 << CW);
      end else begin
        mPend = 0;
      end
    end
    if (flush) begin
      mValid = 0; mExc = 0; mPc = 0; mBd = 0;
    end else if (!stall) begin
      mValid = in_valid; mExc = refMerge(in_valid, in_exc, cur_exc); mPc = in_pc; mBd = in_bd;
    end
    e.v = mValid; e.exc = mExc; e.pc = mPc; e.bd = mBd;
    e.rv = mPend; e.rexc = mRepExc; e.repc = mRepEpc; e.rbd = mRepBd;
    e.kl = (mValid && mExc != 0) || mPend;
    e.cnt = mCnt;
    expQ.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic setIn(input logic v, input logic [EW-1:0] ex, input logic [PW-1:0] pc,
                       input logic bd, input logic [NS*EW-1:0] cur);
    in_valid = v; in_exc = ex; in_pc = pc; in_bd = bd; cur_exc = cur;
  endtask

  // Monitor: compares the DUT against the oldest expectation after each edge.
  initial begin
    Exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        txn++;
        cmp("out_valid", 32'(out_valid), 32'(e.v));
        cmp("out_exc",   32'(out_exc),   32'(e.exc));
        cmp("out_pc",    out_pc,         e.pc);
        cmp("out_bd",    32'(out_bd),    32'(e.bd));
        cmp("rep_valid", 32'(rep_valid), 32'(e.rv));
        cmp("rep_exc",   32'(rep_exc),   32'(e.rexc));
        cmp("rep_epc",   rep_epc,        e.repc);
        cmp("rep_bd",    32'(rep_bd),    32'(e.rbd));
        cmp("kill",      32'(kill),      32'(e.kl));
        cmp("exc_cnt",   32'(exc_cnt),   32'(e.cnt));
        $display("txn %0d: v=%0b exc=%0d pc=%h rep=%0b rexc=%0d epc=%h cnt=%0d",
                 txn, out_valid, out_exc, out_pc, rep_valid, rep_exc, rep_epc, exc_cnt);
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    stall = 0; flush = 0; rep_ack = 0;
    setIn(0, 0, 0, 0, '0);
    modelReset();
    @(negedge clk);
    cmp("rst_out_valid", 32'(out_valid), 0);
    cmp("rst_rep_valid", 32'(rep_valid), 0);
    cmp("rst_exc_cnt",   32'(exc_cnt),   0);
    cmp("rst_kill",      32'(kill),      0);
    @(negedge clk);
    reset_n = 1'b1;

    // Source priority: src1=10 beats src3=12; upstream 4 beats both
    setIn(1, 0, 32'h1000, 0, {5'd12, 5'd0, 5'd10, 5'd0});
    step();
    cmp("prio_src", 32'(out_exc), 10);
    in_exc = 5'd4;
    step();
    cmp("prio_upstream", 32'(out_exc), 4);

    // Stall holds, flush beats stall
    setIn(1, 0, 32'h3000, 0, '0);
    step();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      setIn(1, 5'd10, 32'h5000 + 32'(i * 4), 1, '0);
      step();
      cmp("stall_hold_pc", out_pc, 32'h3000);
    end
    flush = 1;
    step();
    cmp("flush_valid", 32'(out_valid), 0);
    cmp("flush_exc",   32'(out_exc),   0);
    stall = 0; flush = 0;

    // Branch-delay EPC from a clean IDLE state
    setIn(0, 0, 0, 0, '0);
    doReset();
    setIn(1, 5'd12, 32'h3008, 1, '0);
    step();
    cmp("bd_kill_trig", 32'(kill), 1);
    setIn(0, 0, 0, 0, '0);
    step();
    cmp("bd_rep_valid", 32'(rep_valid), 1);
    cmp("bd_rep_epc",   rep_epc,        32'h3004);
    cmp("bd_rep_bd",    32'(rep_bd),    1);
    cmp("bd_exc_cnt",   32'(exc_cnt),   1);
    cmp("bd_kill_pend", 32'(kill),      1);

    // Held report drops a new trig until acknowledged
    setIn(1, 5'd5, 32'h3100, 0, '0);
    step();
    setIn(0, 0, 0, 0, '0);
    step();
    cmp("held_rep_exc", 32'(rep_exc), 12);
    cmp("held_exc_cnt", 32'(exc_cnt), 1);
    rep_ack = 1;
    step();
    cmp("ack_release", 32'(rep_valid), 0);
    rep_ack = 0;

    // Back-to-back: ack and trig together reload the report
    setIn(1, 5'd12, 32'h4000, 0, '0);
    step();
    setIn(1, 5'd8, 32'h4010, 0, '0);
    step();
    setIn(0, 0, 0, 0, '0);
    rep_ack = 1;
    step();
    cmp("b2b_rep_valid", 32'(rep_valid), 1);
    cmp("b2b_rep_exc",   32'(rep_exc),   8);
    cmp("b2b_exc_cnt",   32'(exc_cnt),   3);
    rep_ack = 0;
    setIn(1, 0, 32'h4020, 0, '0);
    step();

    // Asynchronous reset while a report is pending
    #2;
    reset_n = 1'b0;
    #1;
    cmp("arst_rep_valid", 32'(rep_valid), 0);
    cmp("arst_kill",      32'(kill),      0);
    cmp("arst_out_valid", 32'(out_valid), 0);
    cmp("arst_exc_cnt",   32'(exc_cnt),   0);
    modelReset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Counter wrap: four reports bring a 2-bit counter back to 0
    rep_ack = 1;
    for (int i = 0; i < 4; i++) begin
      setIn(1, 5'd5, 32'h6000 + 32'(i * 16), 0, '0);
      step();
      setIn(0, 0, 0, 0, '0);
      step();
      if (i == 2) cmp("wrap_cnt3", 32'(exc_cnt), 3);
    end
    cmp("wrap_cnt0", 32'(exc_cnt), 0);
    rep_ack = 0;

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      logic [NS*EW-1:0] cur;
      cur = '0;
      for (int s = 0; s < NS; s++)
        if ($urandom_range(0, 3) == 0) cur[s*EW +: EW] = codeTab[$urandom_range(1, 5)];
      setIn(1'($urandom_range(0, 3) != 0),
            ($urandom_range(0, 3) == 0) ? codeTab[$urandom_range(1, 5)] : 5'd0,
            {$urandom_range(0, 32'h3FFF), 2'b00}, 1'($urandom_range(0, 1)), cur);
      stall   = ($urandom_range(0, 4) == 0);
      flush   = ($urandom_range(0, 9) == 0);
      rep_ack = ($urandom_range(0, 2) == 0);
      step();
    end

    @(posedge clk);
    #2;
    cmp("queue_drained", 32'(expQ.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exc_stage_reg.md
Name: exc_stage_reg

Overview:
- Parametrised successor to the per-stage exception-code select.
- Merges the upstream exception code with N_SRC exception sources raised in the current stage, using fixed priority.
- Registers the result, with PC and branch-delay flag, as the stage's pipeline register, honouring stall and flush.
- The commit-stage instance also holds a precise-exception report (code, EPC, BD) for CP0 until acknowledged, asserts a pipeline-kill while an exception is in flight, and counts reported exceptions.

Parameters:
- EXC_W, 5, exception code width; code 0 means "no exception".
- N_SRC, 4, number of current-stage exception sources (at least 1).
- PC_W, 32, PC width.
- CNT_W, 8, width of the reported-exception counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- stall  in  1  hold the stage register.
- flush  in  1  clear the stage register to a bubble.
- in_valid  in  1  upstream slot holds a real instruction.
- in_exc  in  EXC_W  exception code carried from upstream.
- in_pc  in  PC_W  instruction PC.
- in_bd  in  1  instruction sits in a branch-delay slot.
- cur_exc  in  N_SRC*EXC_W  current-stage codes; source i occupies bits [i*EXC_W +: EXC_W].
- out_valid  out  1  registered valid.
- out_exc  out  EXC_W  registered merged code.
- out_pc  out  PC_W  registered PC.
- out_bd  out  1  registered BD flag.
- rep_valid  out  1  exception report pending for CP0.
- rep_exc  out  EXC_W  reported code.
- rep_epc  out  PC_W  reported EPC.
- rep_bd  out  1  reported BD flag.
- rep_ack  in  1  CP0 has consumed the report.
- kill  out  1  squash younger instructions.
- exc_cnt  out  CNT_W  number of reports issued, wrapping.

Behaviour:
- Merge (combinational):
  - in_valid=0 gives merged 0.
  - Otherwise, in_exc≠0 gives in_exc. The older fault always wins.
  - Otherwise, the lowest-index i with cur_exc[i]≠0 gives cur_exc[i].
  - Otherwise 0.
- Stage register, priority order:
  - reset_n=0 (async): out_valid=0, out_exc=0, out_pc=0, out_bd=0.
  - flush: same all-zero values on the next edge. Flush beats stall.
  - stall: all out_* hold.
  - Otherwise: load in_valid, merged, in_pc, in_bd.
  - Latency is 1 cycle from inputs to out_*.
- EPC: equals out_pc−4 (modulo 2^PC_W) when out_bd=1, else out_pc.
- Report latch, two states IDLE and PEND:
  - Define trig = out_valid & (out_exc≠0).
  - IDLE & trig: next edge goes to PEND. rep_exc, rep_epc and rep_bd capture out_exc, EPC and out_bd. exc_cnt increments.
  - PEND & rep_ack & trig: stay in PEND and reload from the new trig (back-to-back reports). exc_cnt increments.
  - PEND & rep_ack & !trig: go to IDLE. rep_* keep their last values.
  - PEND & !rep_ack: hold. Any trig in this state is dropped and exc_cnt does not change.
  - rep_ack in IDLE is ignored.
  - stall does not gate the report latch. Only trig and rep_ack matter.
- rep_valid is 1 exactly in PEND.
- kill is combinational: trig | rep_valid.
- Reset values: state IDLE, rep_valid=0, rep_exc=0, rep_epc=0, rep_bd=0, exc_cnt=0.
- exc_cnt wraps from 2^CNT_W−1 to 0.
- Reset asserted mid-PEND clears everything immediately, without waiting for a clock edge.

Decomposition:
- Shared package (mips_exc_pkg) holds:
  - EXC_W.
  - The ExcCode constants: EXC_NONE=0, EXC_INT=0, EXC_ADEL=4, EXC_ADES=5, EXC_RI=10, EXC_OV=12, EXC_SYSCALL=8.
  - The PC step constant 4.
- One sub-module, exc_prio_sel: the combinational upstream-then-lowest-index merge. It is reused standalone in the non-commit stages.

Test Plan:
1. Source priority.
   - Stimulus: in_valid=1, in_exc=0, cur_exc={src3=12, src2=0, src1=10, src0=0}.
   - Required: out_exc=10 one cycle later.
   - Then set in_exc=4.
   - Required: out_exc=4.
2. Stall and flush.
   - Stimulus: load pc=0x3000, then stall=1 for 3 cycles with the inputs changing.
   - Required: out_pc holds 0x3000.
   - Stimulus: assert stall=1 and flush=1 together.
   - Required: out_valid=0, out_exc=0.
3. Branch-delay EPC.
   - Stimulus: out_pc=0x3008, out_bd=1, out_exc=12, state IDLE.
   - Required next cycle: rep_valid=1, rep_epc=0x3004, rep_bd=1, exc_cnt=1.
   - Required throughout: kill=1 from trig onward.
4. Held report.
   - Stimulus: while in PEND with rep_ack=0, present a new trig with code 5.
   - Required: rep_exc is unchanged and exc_cnt is unchanged.
   - Stimulus: rep_ack=1 with no trig.
   - Required: rep_valid=0 next cycle.
5. Back-to-back.
   - Stimulus: in PEND, rep_ack=1 in the same cycle as trig with code 8.
   - Required: rep_valid stays 1, rep_exc=8, exc_cnt increments.
   - Stimulus: with CNT_W=2, issue 4 reports.
   - Required: exc_cnt=0.
6. Asynchronous reset.
   - Stimulus: pull reset_n low mid-PEND, between clock edges.
   - Required: rep_valid, kill, out_valid and exc_cnt all go to 0 immediately.
